fetch_stage: RTL and testbench

- IF stage plus IF/ID pipeline register of the RV32I pipelined core; sits directly upstream of decode/control_unit.
- Owns the PC and drives the synchronous instruction memory address; applies branch/jump redirects and stall/flush requests from the hazard logic.
- Delivers instr_d, pc_d, pc_plus4_d and valid_d to decode; control_unit takes opcode/funct3/funct7 from instr_d.

---
 rtl/rv_pkg.sv | 33 +++
 rtl/fetch_stage_if.sv | 10 +
 rtl/fetch_stage_if_id_reg.sv | 34 +++
 rtl/fetch_stage.sv | 80 ++++++++
 tb/tb_fetch_stage.sv | 136 +++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32I core constants, opcodes and pipeline types
// Purpose: constants and types shared by the fetch stage and decode/control.
// Ports: none (package).
package rv_pkg;

  localparam logic [31:0] RESET_PC  = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory bus between fetch and imem
// Purpose: groups the synchronous instruction memory address/data pair.
// Signals: imem_addr (fetch -> memory), imem_rdata (memory -> fetch, 1-cycle latency).
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  modport master (output imem_addr, input imem_rdata);
  modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register with flush/stall priority
// Purpose: holds the fetched instruction for decode and counts valid loads.
// Ports: clk, rst_n (async active-low), flush, stall, bubble (fetch in BOOT),
//        d (next IF/ID contents), q (current IF/ID contents), count (valid loads).
module if_id_reg
  import rv_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        stall,
  input  logic        bubble,
  input  if_id_t      d,
  output if_id_t      q,
  output logic [31:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '{instr: BUBBLE_INSTR, pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0};
      count <= 32'h0;
    end else if (flush || (!stall && bubble)) begin
      // Bubble keeps the old pc fields; only the instruction and valid change.
      q.instr <= BUBBLE_INSTR;
      q.valid <= 1'b0;
    end else if (!stall) begin
      q     <= d;
      count <= count + 32'h1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I IF stage: PC, boot FSM, redirect and IF/ID register
// Purpose: drives the imem address, applies redirects/stalls/flushes, feeds decode.
// Ports: clk, rst_n (async active-low), stall_f, stall_d, flush_d,
//        redirect_valid, redirect_target, imem (fetch_stage_if.master),
//        instr_d, pc_d, pc_plus4_d, valid_d, fetch_count.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = rv_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_f,
  input  logic                  stall_d,
  input  logic                  flush_d,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_target,
  fetch_stage_if.master         imem,
  output logic [31:0]           instr_d,
  output logic [31:0]           pc_d,
  output logic [31:0]           pc_plus4_d,
  output logic                  valid_d,
  output logic [31:0]           fetch_count
);

  import rv_pkg::*;

  fetch_state_t state, next_state;
  logic [31:0]  pc_f, pc_next;
  if_id_t       if_id_next, if_id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc_f  <= RESET_PC;
    end else begin
      state <= next_state;
      pc_f  <= pc_next;
    end
  end

  // In BOOT the memory has not yet returned the word at pc_f, so pc_f is
  // re-presented rather than advanced. A redirect still wins.
  always_comb begin
    next_state = RUN;
    pc_next    = pc_f + 32'h4;
    if (redirect_valid) begin
      pc_next = redirect_target & ~32'h3;
    end else if (stall_f || state == BOOT) begin
      pc_next = pc_f;
    end
  end

  assign imem.imem_addr = pc_next;

  always_comb begin
    if_id_next.instr    = imem.imem_rdata;
    if_id_next.pc       = pc_f;
    if_id_next.pc_plus4 = pc_f + 32'h4;
    if_id_next.valid    = 1'b1;
  end

  if_id_reg #(
    .BUBBLE_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush_d),
    .stall  (stall_d),
    .bubble (state == BOOT),
    .d      (if_id_next),
    .q      (if_id_q),
    .count  (fetch_count)
  );

  assign instr_d    = if_id_q.instr;
  assign pc_d       = if_id_q.pc;
  assign pc_plus4_d = if_id_q.pc_plus4;
  assign valid_d    = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [31:0] instr_d, pc_d, pc_plus4_d, fetch_count;
  logic        valid_d;

  int passed = 0;
  int total  = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_f         (stall_f),
    .stall_d         (stall_d),
    .flush_d         (flush_d),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem            (bus),
    .instr_d         (instr_d),
    .pc_d            (pc_d),
    .pc_plus4_d      (pc_plus4_d),
    .valid_d         (valid_d),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h0050_0093;
    return {a[15:0], 16'h0013};
  endfunction

  always @(posedge clk) bus.imem_rdata <= mem_word(bus.imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_outs(input string tag, input logic [31:0] e_instr, input logic [31:0] e_pc,
                          input logic [31:0] e_pc4, input logic e_valid, input logic [31:0] e_cnt);
    chk({tag, ".instr_d"},     instr_d,          e_instr);
    chk({tag, ".pc_d"},        pc_d,             e_pc);
    chk({tag, ".pc_plus4_d"},  pc_plus4_d,       e_pc4);
    chk({tag, ".valid_d"},     {31'h0, valid_d}, {31'h0, e_valid});
    chk({tag, ".fetch_count"}, fetch_count,      e_cnt);
  endtask

  typedef struct {
    logic        sf, sd, fl, rv;
    logic [31:0] tgt;
    logic [31:0] e_addr;
    logic [31:0] e_instr, e_pc, e_pc4;
    logic        e_valid;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[17];

  initial begin
    // sf sd fl rv  target         imem_addr      instr_d        pc_d           pc_plus4_d     v  count
    vecs[0]  = '{0,0,0,0, 32'h0,          32'hBFC00000, NOP,           32'h0,         32'h0,         0, 32'd0};
    vecs[1]  = '{0,0,0,0, 32'h0,          32'hBFC00004, 32'h00500093,  32'hBFC00000,  32'hBFC00004,  1, 32'd1};
    vecs[2]  = '{0,0,0,0, 32'h0,          32'hBFC00008, 32'h00040013,  32'hBFC00004,  32'hBFC00008,  1, 32'd2};
    vecs[3]  = '{1,1,0,0, 32'h0,          32'hBFC00008, 32'h00040013,  32'hBFC00004,  32'hBFC00008,  1, 32'd2};
    vecs[4]  = '{1,1,0,0, 32'h0,          32'hBFC00008, 32'h00040013,  32'hBFC00004,  32'hBFC00008,  1, 32'd2};
    vecs[5]  = '{0,0,0,0, 32'h0,          32'hBFC0000C, 32'h00080013,  32'hBFC00008,  32'hBFC0000C,  1, 32'd3};
    vecs[6]  = '{0,0,0,0, 32'h0,          32'hBFC00010, 32'h000C0013,  32'hBFC0000C,  32'hBFC00010,  1, 32'd4};
    vecs[7]  = '{0,0,1,1, 32'hBFC00043,   32'hBFC00040, NOP,           32'hBFC0000C,  32'hBFC00010,  0, 32'd4};
    vecs[8]  = '{0,0,0,0, 32'h0,          32'hBFC00044, 32'h00400013,  32'hBFC00040,  32'hBFC00044,  1, 32'd5};
    vecs[9]  = '{1,1,0,1, 32'hBFC00100,   32'hBFC00100, 32'h00400013,  32'hBFC00040,  32'hBFC00044,  1, 32'd5};
    vecs[10] = '{0,0,0,0, 32'h0,          32'hBFC00104, 32'h01000013,  32'hBFC00100,  32'hBFC00104,  1, 32'd6};
    vecs[11] = '{0,1,1,0, 32'h0,          32'hBFC00108, NOP,           32'hBFC00100,  32'hBFC00104,  0, 32'd6};
    vecs[12] = '{0,1,0,0, 32'h0,          32'hBFC0010C, NOP,           32'hBFC00100,  32'hBFC00104,  0, 32'd6};
    vecs[13] = '{1,0,0,0, 32'h0,          32'hBFC0010C, 32'h010C0013,  32'hBFC0010C,  32'hBFC00110,  1, 32'd7};
    vecs[14] = '{0,0,0,1, 32'hFFFFFFFE,   32'hFFFFFFFC, 32'h010C0013,  32'hBFC0010C,  32'hBFC00110,  1, 32'd8};
    vecs[15] = '{0,0,0,0, 32'h0,          32'h00000000, 32'hFFFC0013,  32'hFFFFFFFC,  32'h00000000,  1, 32'd9};
    vecs[16] = '{0,0,0,0, 32'h0,          32'h00000004, 32'h00000013,  32'h00000000,  32'h00000004,  1, 32'd10};

    // Reset state while rst_n is held low.
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", NOP, 32'h0, 32'h0, 1'b0, 32'd0);
    chk("reset.imem_addr", bus.imem_addr, 32'hBFC00000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      stall_f         = vecs[i].sf;
      stall_d         = vecs[i].sd;
      flush_d         = vecs[i].fl;
      redirect_valid  = vecs[i].rv;
      redirect_target = vecs[i].tgt;
      #1;
      chk($sformatf("v%0d.imem_addr", i), bus.imem_addr, vecs[i].e_addr);
      @(posedge clk);
      #1;
      chk_outs($sformatf("v%0d", i), vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_pc4,
               vecs[i].e_valid, vecs[i].e_cnt);
    end

    stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; redirect_valid = 1'b0;
    redirect_target = 32'h0;

    // Mid-run asynchronous reset, held for half a cycle between edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("midrst", NOP, 32'h0, 32'h0, 1'b0, 32'd0);
    chk("midrst.imem_addr", bus.imem_addr, 32'hBFC00000);
    #4;
    rst_n = 1'b1;
    #1;
    chk("boot2.imem_addr", bus.imem_addr, 32'hBFC00000);
    @(posedge clk);
    #1;
    chk_outs("boot2", NOP, 32'h0, 32'h0, 1'b0, 32'd0);
    chk("run2.imem_addr", bus.imem_addr, 32'hBFC00004);
    @(posedge clk);
    #1;
    chk_outs("run2", 32'h00500093, 32'hBFC00000, 32'hBFC00004, 1'b1, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
